// File: rtl/temp_alarm_sequencer_if.sv
// Bus between the temperature switch inputs and the LED/alarm/fan outputs of the sequencer.
// The master drives the switch code and ack; the slave (sequencer) drives the status outputs.
interface temp_alarm_sequencer_if;
  logic [2:0] temp_code;
  logic       ack;
  logic       prev_led;
  logic       alarm;
  logic       fan_on;
  logic [1:0] state;

  modport master (
    output temp_code,
    output ack,
    input  prev_led,
    input  alarm,
    input  fan_on,
    input  state
  );

  modport slave (
    input  temp_code,
    input  ack,
    output prev_led,
    output alarm,
    output fan_on,
    output state
  );
endinterface

// File: rtl/temp_alarm_sequencer.sv
// Debounces the 3-bit temperature switch code and sequences the preventive LED, the latched
// alarm and the fan (with a timed cooldown run-on).
module temp_alarm_sequencer #(
  parameter int unsigned STABLE_CYCLES = 16,
  parameter int unsigned HOLD_CYCLES   = 1000,
  parameter logic [2:0]  PREV_CODE     = 3'b110,
  parameter logic [2:0]  ALARM_CODE    = 3'b111
) (
  input logic                    clk,
  input logic                    reset,
  temp_alarm_sequencer_if.slave  bus
);

  localparam int unsigned CntW  = $clog2(STABLE_CYCLES) + 1;
  localparam int unsigned HoldW = $clog2(HOLD_CYCLES) + 1;

  typedef enum logic [1:0] {
    StNormal   = 2'b00,
    StPrevent  = 2'b01,
    StAlarm    = 2'b10,
    StCooldown = 2'b11
  } state_e;

  logic [2:0]      r_sync;
  logic [2:0]      r_cand;
  logic [2:0]      r_filt;
  logic [CntW-1:0] r_cnt;

  // temp_code is asynchronous; r_sync is its single capture stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= '0;
      r_cand <= '0;
      r_filt <= '0;
      r_cnt  <= '0;
    end else begin
      r_sync <= bus.temp_code;
      if (r_sync != r_cand) begin
        r_cand <= r_sync;
        r_cnt  <= '0;
      end else if (r_cnt == CntW'(STABLE_CYCLES - 1)) begin
        r_filt <= r_cand;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  logic w_hi;
  logic w_mid;
  logic w_lo;

  assign w_hi  = (r_filt >= ALARM_CODE);
  assign w_mid = (r_filt >= PREV_CODE) && !w_hi;
  assign w_lo  = !w_hi && !w_mid;

  state_e           r_state;
  state_e           w_state_d;
  logic [HoldW-1:0] r_hold;
  logic [HoldW-1:0] w_hold_d;
  logic             r_prev_led;
  logic             r_alarm;
  logic             r_fan_on;
  logic             w_prev_led_d;
  logic             w_alarm_d;
  logic             w_fan_on_d;

  always_comb begin
    w_state_d = r_state;
    w_hold_d  = r_hold;
    unique case (r_state)
      StNormal: begin
        if (w_hi) begin
          w_state_d = StAlarm;
        end else if (w_mid) begin
          w_state_d = StPrevent;
        end
      end
      StPrevent: begin
        if (w_hi) begin
          w_state_d = StAlarm;
        end else if (w_lo) begin
          w_state_d = StCooldown;
          w_hold_d  = HoldW'(HOLD_CYCLES - 1);
        end
      end
      StAlarm: begin
        // Latched: only an ack after the temperature has dropped releases it.
        if (!w_hi && bus.ack) begin
          if (w_mid) begin
            w_state_d = StPrevent;
          end else begin
            w_state_d = StCooldown;
            w_hold_d  = HoldW'(HOLD_CYCLES - 1);
          end
        end
      end
      StCooldown: begin
        if (w_hi) begin
          w_state_d = StAlarm;
          w_hold_d  = '0;
        end else if (w_mid) begin
          w_state_d = StPrevent;
          w_hold_d  = '0;
        end else if (r_hold == '0) begin
          w_state_d = StNormal;
        end else begin
          w_hold_d = r_hold - 1'b1;
        end
      end
      default: begin
        w_state_d = StNormal;
        w_hold_d  = '0;
      end
    endcase

    w_prev_led_d = (w_state_d == StPrevent);
    w_alarm_d    = (w_state_d == StAlarm);
    w_fan_on_d   = (w_state_d != StNormal);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= StNormal;
      r_hold     <= '0;
      r_prev_led <= 1'b0;
      r_alarm    <= 1'b0;
      r_fan_on   <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_hold     <= w_hold_d;
      r_prev_led <= w_prev_led_d;
      r_alarm    <= w_alarm_d;
      r_fan_on   <= w_fan_on_d;
    end
  end

  assign bus.prev_led = r_prev_led;
  assign bus.alarm    = r_alarm;
  assign bus.fan_on   = r_fan_on;
  assign bus.state    = r_state;

endmodule

// File: tb/tb_temp_alarm_sequencer.sv
// Directed bench for temp_alarm_sequencer: a table of {inputs, cycles, expected outputs} rows
// plus hand-written sequences for glitch rejection and the exact cooldown length.
module tb_temp_alarm_sequencer;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  temp_alarm_sequencer_if bus ();

  temp_alarm_sequencer #(
    .STABLE_CYCLES(16),
    .HOLD_CYCLES  (1000),
    .PREV_CODE    (3'b110),
    .ALARM_CODE   (3'b111)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       rst;
    logic [2:0] code;
    logic       ack;
    int         cycles;
    logic [1:0] exp_state;
    logic       exp_prev;
    logic       exp_alarm;
    logic       exp_fan;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string name, input logic rst, input logic [2:0] code, input logic ack,
                     input int cycles, input logic [1:0] st, input logic p, input logic a,
                     input logic f);
    vec_t v;
    v.name      = name;
    v.rst       = rst;
    v.code      = code;
    v.ack       = ack;
    v.cycles    = cycles;
    v.exp_state = st;
    v.exp_prev  = p;
    v.exp_alarm = a;
    v.exp_fan   = f;
    vecs.push_back(v);
  endtask

  // Advance one rising edge and land 1 ns after it, away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got {state,prev,alarm,fan}=%b expected %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [4:0] outs();
    return {bus.state, bus.prev_led, bus.alarm, bus.fan_on};
  endfunction

  initial begin
    int n;
    int bad;
    errors        = 0;
    checks        = 0;
    reset         = 1'b1;
    bus.temp_code = 3'b111;
    bus.ack       = 1'b0;

    // Reset and alarm latency: 111 is first seen at edge 19 after release.
    add("reset_hold",        1, 3'b111, 0,    3, 2'b00, 0, 0, 0);
    add("alarm_latency_18",  0, 3'b111, 0,   18, 2'b00, 0, 0, 0);
    add("alarm_edge_19",     0, 3'b111, 0,    1, 2'b10, 0, 1, 1);
    add("alarm_latched",     0, 3'b000, 0,  100, 2'b10, 0, 1, 1);
    add("ack_to_cooldown",   0, 3'b000, 1,    1, 2'b11, 0, 0, 1);
    add("cooldown_998",      0, 3'b000, 0,  998, 2'b11, 0, 0, 1);
    add("cooldown_999",      0, 3'b000, 0,    1, 2'b11, 0, 0, 1);
    add("cooldown_done",     0, 3'b000, 0,    1, 2'b00, 0, 0, 0);
    // Ack while hot is ignored.
    add("hot_ack_18",        0, 3'b111, 1,   18, 2'b00, 0, 0, 0);
    add("hot_ack_alarm",     0, 3'b111, 1,    1, 2'b10, 0, 1, 1);
    add("hot_ack_stays",     0, 3'b111, 1,   10, 2'b10, 0, 1, 1);
    add("reset_mid_alarm",   1, 3'b111, 1,    1, 2'b00, 0, 0, 0);
    add("post_reset_idle",   0, 3'b000, 0,   20, 2'b00, 0, 0, 0);
    // Debounce: 15-cycle pulse rejected, held code accepted at edge 19.
    add("glitch_15",         0, 3'b110, 0,   15, 2'b00, 0, 0, 0);
    add("glitch_gone",       0, 3'b000, 0,   30, 2'b00, 0, 0, 0);
    add("prevent_18",        0, 3'b110, 0,   18, 2'b00, 0, 0, 0);
    add("prevent_edge_19",   0, 3'b110, 0,    1, 2'b01, 1, 0, 1);
    add("prevent_hold",      0, 3'b000, 0,   18, 2'b01, 1, 0, 1);
    add("prevent_to_cool",   0, 3'b000, 0,    1, 2'b11, 0, 0, 1);
    // Re-heat at cooldown cycle 500, then a fresh full-length cooldown.
    add("cool_499",          0, 3'b000, 0,  499, 2'b11, 0, 0, 1);
    add("reheat_18",         0, 3'b110, 0,   18, 2'b11, 0, 0, 1);
    add("reheat_prevent",    0, 3'b110, 0,    1, 2'b01, 1, 0, 1);
    add("recool_18",         0, 3'b000, 0,   18, 2'b01, 1, 0, 1);
    add("recool_entry",      0, 3'b000, 0,    1, 2'b11, 0, 0, 1);
    add("recool_999",        0, 3'b000, 0,  999, 2'b11, 0, 0, 1);
    add("recool_done",       0, 3'b000, 0,    1, 2'b00, 0, 0, 0);
    // Cooldown interrupted by alarm level.
    add("to_prevent",        0, 3'b110, 0,   19, 2'b01, 1, 0, 1);
    add("to_cool",           0, 3'b000, 0,   19, 2'b11, 0, 0, 1);
    add("cool_to_alarm",     0, 3'b111, 0,   19, 2'b10, 0, 1, 1);
    add("alarm_ack_mid",     0, 3'b110, 1,   19, 2'b01, 1, 0, 1);

    #1;
    foreach (vecs[i]) begin
      reset         = vecs[i].rst;
      bus.temp_code = vecs[i].code;
      bus.ack       = vecs[i].ack;
      for (int c = 0; c < vecs[i].cycles; c++) tick();
      check(vecs[i].name, outs(),
            {vecs[i].exp_state, vecs[i].exp_prev, vecs[i].exp_alarm, vecs[i].exp_fan});
    end

    // Return to a known idle state.
    reset         = 1'b1;
    bus.temp_code = 3'b000;
    bus.ack       = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check("seq_reset_idle", outs(), 5'b00_000);

    // Glitch of 15 cycles: outputs must stay idle on every cycle.
    bad           = 0;
    bus.temp_code = 3'b110;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (outs() != 5'b00_000) bad++;
    end
    bus.temp_code = 3'b000;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (outs() != 5'b00_000) bad++;
    end
    check_int("glitch_every_cycle", bad, 0);

    // Exact cooldown length counted from PREVENT with a bounded wait.
    bus.temp_code = 3'b110;
    n = 0;
    while (bus.state != 2'b01 && n < 100) begin
      tick();
      n++;
    end
    check_int("prevent_latency", n, 19);
    bus.temp_code = 3'b000;
    n = 0;
    while (bus.state != 2'b11 && n < 100) begin
      tick();
      n++;
    end
    check_int("cool_entry_latency", n, 19);
    n   = 0;
    bad = 0;
    while (bus.state == 2'b11 && n < 2000) begin
      if (bus.fan_on !== 1'b1) bad++;
      n++;
      tick();
    end
    check_int("cooldown_length", n, 1000);
    check_int("cooldown_fan_held", bad, 0);
    check("cooldown_end_idle", outs(), 5'b00_000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
